interval_sched: RTL
===================

# interval_sched

Two-requester interval scheduler built around an 8-bit presettable up-counter made of two cascaded 4-bit synchronous counter stages. It grants the shared counter to one requester at a time using round-robin arbitration. It loads the requester's interval length as a preset, sequences counting with hold support, and returns a one-cycle completion pulse to the owner. It is the controller that turns the presettable counter into a shared, schedulable timer resource.

## Interface
- No parameters; requester count fixed at 2, interval width fixed at 8 bits (two 4-bit stages).
- CP  in  1  clock; all state changes on rising edge.
- CR  in  1  reset; synchronous, active-low.
- REQ  in  2  per-requester request level; REQ[i] must stay high until DONE[i].
- LEN0  in  8  interval length for requester 0, sampled in LOAD.
- LEN1  in  8  interval length for requester 1, sampled in LOAD.
- HOLD  in  1  pauses counting while high; the counter keeps its value.
- GNT  out  2  one-hot grant; high from LOAD through DONE state inclusive.
- DONE  out  2  one-cycle completion pulse to the owner.
- BUSY  out  1  high in any state other than IDLE.
- CNT  out  8  current counter value.

## Operation
- FSM states: IDLE, LOAD, RUN, FIN.
- IDLE:
  - If REQ≠0, pick the owner: if both requesters are requesting, pick the one not equal to LAST; otherwise pick the sole requester.
  - Latch OWNER and go to LOAD.
- LOAD:
  - Assert the counter PE; preset D = ~LEN[OWNER] (that is, 255−LEN).
  - Go to RUN.
- RUN:
  - Counter enable CE = ~HOLD.
  - The low stage counts when CE is high.
  - The high stage counts when CE is high and the low stage TC is high (low nibble = F).
  - When CNT==8'hFF, go to FIN; the counter does not advance in that cycle.
- FIN:
  - DONE[OWNER]=1.
  - LAST<=OWNER.
  - Go to IDLE.
- Abort: if REQ[OWNER] falls during LOAD or RUN, go to IDLE next cycle. No DONE pulse is issued, LAST<=OWNER, and CNT keeps its value.
- LEN=0: preset 8'hFF, so RUN lasts exactly 1 cycle.
- LEN=255: preset 8'h00, so RUN lasts 256 cycles without HOLD.
- LEN changes after LOAD are ignored.
- New requests during LOAD, RUN or FIN are not arbitrated until IDLE. One IDLE cycle always separates grants.
- Reset (CR low at a rising edge), from any state including mid-interval:
  - state = IDLE, CNT = 0, GNT = 0, DONE = 0, BUSY = 0.
  - LAST = 1, so requester 0 wins the first tie.

## Timing
- REQ sampled high in IDLE at edge t → LOAD during cycle t+1, with GNT and BUSY high.
- CNT = 255−LEN in the first RUN cycle (t+2).
- Without HOLD, CNT reaches 8'hFF at t+2+LEN, FIN and the DONE pulse fall at t+3+LEN, and the block is back in IDLE at t+4+LEN.
- Grant-to-DONE latency is LEN+2 cycles plus the number of RUN cycles with HOLD high.
- HOLD is ignored outside RUN.
- HOLD high in the cycle CNT==8'hFF does not delay FIN.
- All outputs are registered or decoded from registered state; there are no combinational paths from inputs to outputs.

## Structure
- Shared package interval_sched_pkg holds:
  - the state encoding (IDLE=2'd0, LOAD=2'd1, RUN=2'd2, FIN=2'd3);
  - CNT_MAX = 8'hFF;
  - the reset value of LAST.
- Sub-module cnt4_preset, instantiated twice:
  - ports CP, CR, PE, CEP, CET, D[3:0], Q[3:0], TC;
  - synchronous active-low clear, synchronous load when PE is low, count when CEP & CET are high;
  - TC = CET & (Q==4'hF).
- The low stage's TC drives the high stage's CET.
- The top level contains the FSM, the round-robin pointer, the preset mux and output decode.

## Test plan
- Single request: REQ=01, LEN0=3, no HOLD → GNT=01 at t+1, CNT sequence 252,253,254,255, DONE=01 at t+6, BUSY low at t+7.
- Tie and fairness: after reset, REQ=11 held throughout, LEN0=LEN1=1 → grants alternate 01,10,01, with one IDLE cycle between each FIN and the next LOAD.
- HOLD: REQ=10, LEN1=4, HOLD high for 3 RUN cycles mid-count → DONE=10 arrives 3 cycles later than without HOLD, and CNT is frozen during HOLD.
- Boundaries:
  - LEN0=0 → RUN lasts 1 cycle with CNT=255, DONE at t+3.
  - LEN0=255 → CNT passes 8'h0F→8'h10 (nibble carry), DONE at t+258.
- Abort and reset:
  - REQ[0] dropped at RUN cycle 2 → IDLE next cycle, no DONE, and the next tie is won by requester 1.
  - CR low mid-RUN → next cycle all outputs 0, CNT=0, state IDLE.

Source files
------------

// File: rtl/interval_sched_pkg.sv
// Shared types and constants for the two-requester interval scheduler.
// Holds the FSM encoding, counter limit and round-robin helper.
package interval_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_FIN  = 2'd3
  } state_e;

  localparam logic [7:0] CNT_MAX  = 8'hFF;
  localparam logic       LAST_RST = 1'b1;

  // On a tie the requester that did not own the counter last wins.
  function automatic logic rr_pick(
    input logic [1:0] req,
    input logic       last
  );
    return (req == 2'b11) ? ~last : req[1];
  endfunction

endpackage

// File: rtl/interval_sched_cnt4_preset.sv
// 4-bit synchronous presettable up-counter stage.
// Active-low clear and load; TC ripples into the next stage's CET.
module cnt4_preset (
  input  logic       CP,
  input  logic       CR,
  input  logic       PE,
  input  logic       CEP,
  input  logic       CET,
  input  logic [3:0] D,
  output logic [3:0] Q,
  output logic       TC
);

  logic [3:0] q_q;

  always_ff @(posedge CP) begin
    if (!CR) begin
      q_q <= 4'd0;
    end else if (!PE) begin
      q_q <= D;
    end else if (CEP && CET) begin
      q_q <= q_q + 4'd1;
    end
  end

  assign Q  = q_q;
  assign TC = CET & (q_q == 4'hF);

endmodule

// File: rtl/interval_sched.sv
// Round-robin scheduler sharing one 8-bit presettable counter
// between two requesters; returns a DONE pulse per interval.
module interval_sched
  import interval_sched_pkg::*;
(
  input  logic       CP,
  input  logic       CR,
  input  logic [1:0] REQ,
  input  logic [7:0] LEN0,
  input  logic [7:0] LEN1,
  input  logic       HOLD,
  output logic [1:0] GNT,
  output logic [1:0] DONE,
  output logic       BUSY,
  output logic [7:0] CNT
);

  state_e     state_q;
  logic       owner_q;
  logic       last_q;
  logic [1:0] gnt_q;
  logic [1:0] done_q;
  logic       busy_q;

  logic       req_own;
  logic       pick;
  logic       pe_n;
  logic       run_act;
  logic       cep;
  logic       tc_lo;
  logic       tc_hi;
  logic [7:0] preset;

  assign req_own = REQ[owner_q];
  assign pick    = rr_pick(REQ, last_q);
  assign preset  = owner_q ? ~LEN1 : ~LEN0;

  // An abort in LOAD must leave the counter untouched.
  assign pe_n    = !((state_q == S_LOAD) && req_own);
  assign run_act = (state_q == S_RUN) && req_own;
  assign cep     = !HOLD && !tc_hi;

  cnt4_preset u_lo (
    .CP  (CP),
    .CR  (CR),
    .PE  (pe_n),
    .CEP (cep),
    .CET (run_act),
    .D   (preset[3:0]),
    .Q   (CNT[3:0]),
    .TC  (tc_lo)
  );

  cnt4_preset u_hi (
    .CP  (CP),
    .CR  (CR),
    .PE  (pe_n),
    .CEP (cep),
    .CET (tc_lo),
    .D   (preset[7:4]),
    .Q   (CNT[7:4]),
    .TC  (tc_hi)
  );

  always_ff @(posedge CP) begin
    if (!CR) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      last_q  <= LAST_RST;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (|REQ) begin
            owner_q <= pick;
            gnt_q   <= pick ? 2'b10 : 2'b01;
            busy_q  <= 1'b1;
            state_q <= S_LOAD;
          end
        end
        S_LOAD, S_RUN: begin
          if (!req_own) begin
            last_q  <= owner_q;
            gnt_q   <= 2'b00;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (state_q == S_LOAD) begin
            state_q <= S_RUN;
          end else if (CNT == CNT_MAX) begin
            done_q  <= gnt_q;
            state_q <= S_FIN;
          end
        end
        S_FIN: begin
          last_q  <= owner_q;
          gnt_q   <= 2'b00;
          done_q  <= 2'b00;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign GNT  = gnt_q;
  assign DONE = done_q;
  assign BUSY = busy_q;

endmodule
